uinstr_exec: RTL

UINSTR_EXEC -- requirements
Module: uinstr_exec

---
 rtl/uinstr_exec.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uinstr_exec.sv
// Micro-instruction executor: 16-entry register file, two-operand ALU with a
// widening multiply that writes back its high half one cycle after the low half.
package config_pkg;
   localparam int AW = 4;
   localparam int DW = 20;
   localparam int CW = 4;

   typedef struct packed {
      logic [AW-1:0] vrs1;
      logic [AW-1:0] vrs2;
      logic [AW-1:0] vrs3;
      logic [CW-1:0] opcode;
   } uinstr_t;

   typedef logic [2*DW-1:0] w_data_t;
endpackage

module uinstr_exec
   import config_pkg::*;
(
   input  logic          clk_i,
   input  logic          rst_i,
   input  uinstr_t       uinstr_i,
   input  logic          uinstr_valid_i,
   output logic          uinstr_ready_o,
   input  logic          reg_we_i,
   input  logic [AW-1:0] reg_waddr_i,
   input  logic [DW-1:0] reg_wdata_i,
   input  logic [AW-1:0] reg_raddr_i,
   output logic [DW-1:0] reg_rdata_o,
   output logic          done_o,
   output logic          err_o,
   output logic [1:0]    state_o
);

   // Handshake: an instruction transfers at a rising edge where
   // uinstr_valid_i and uinstr_ready_o are both high; the initiator holds
   // uinstr_i stable until that edge.

   localparam logic [CW-1:0] OP_NOP = 4'd0;
   localparam logic [CW-1:0] OP_ADD = 4'd1;
   localparam logic [CW-1:0] OP_SUB = 4'd2;
   localparam logic [CW-1:0] OP_AND = 4'd3;
   localparam logic [CW-1:0] OP_OR  = 4'd4;
   localparam logic [CW-1:0] OP_XOR = 4'd5;
   localparam logic [CW-1:0] OP_MUL = 4'd6;
   localparam logic [CW-1:0] OP_MOV = 4'd7;

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB_HI = 2'd2} state_t;

   state_t        state;
   logic [DW-1:0] regs [2**AW];
   logic [CW-1:0] op_q;
   logic [AW-1:0] dst_q;
   logic [AW-1:0] dst_hi;
   logic [DW-1:0] a_q;
   logic [DW-1:0] b_q;
   logic [DW-1:0] hi_q;
   w_data_t       prod;
   logic [DW-1:0] result;
   logic          wr_en;
   logic          illegal;

   assign uinstr_ready_o = (state == IDLE) && !rst_i;
   assign reg_rdata_o    = regs[reg_raddr_i];
   assign state_o        = state;
   assign dst_hi         = dst_q + 1'b1;

   always_comb begin
      prod    = w_data_t'(a_q) * w_data_t'(b_q);
      result  = '0;
      wr_en   = 1'b1;
      illegal = 1'b0;
      case (op_q)
         OP_NOP:  wr_en  = 1'b0;
         OP_ADD:  result = a_q + b_q;
         OP_SUB:  result = a_q - b_q;
         OP_AND:  result = a_q & b_q;
         OP_OR:   result = a_q | b_q;
         OP_XOR:  result = a_q ^ b_q;
         OP_MUL:  result = prod[DW-1:0];
         OP_MOV:  result = a_q;
         default: begin
            wr_en   = 1'b0;
            illegal = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= IDLE;
         done_o <= 1'b0;
         err_o  <= 1'b0;
         op_q   <= '0;
         dst_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         hi_q   <= '0;
         for (int i = 0; i < 2**AW; i++) regs[i] <= '0;
      end else begin
         done_o <= 1'b0;
         err_o  <= 1'b0;
         // Host write goes first so a same-address internal write-back below overrides it.
         if (reg_we_i) regs[reg_waddr_i] <= reg_wdata_i;
         case (state)
            IDLE: begin
               if (uinstr_valid_i) begin
                  op_q  <= uinstr_i.opcode;
                  dst_q <= uinstr_i.vrs3;
                  a_q   <= regs[uinstr_i.vrs1];
                  b_q   <= regs[uinstr_i.vrs2];
                  state <= EXEC;
               end
            end
            EXEC: begin
               if (wr_en) regs[dst_q] <= result;
               if (op_q == OP_MUL) begin
                  hi_q  <= prod[2*DW-1:DW];
                  state <= WB_HI;
               end else begin
                  done_o <= 1'b1;
                  err_o  <= illegal;
                  state  <= IDLE;
               end
            end
            WB_HI: begin
               regs[dst_hi] <= hi_q;
               done_o       <= 1'b1;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
